// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, reset PC and the
// {pc, instr} record that travels from fetch to decode.
package riscv_pkg;

    localparam int          D_WIDTH   = 32;
    localparam int          MEM_DEPTH = 1024;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]        pc;
        logic [D_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: {pc, instr} offered with valid, accepted with ready.
interface fetch_unit_if #(
    parameter int D_WIDTH = riscv_pkg::D_WIDTH
);

    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_instr;
    logic [31:0]        out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush empties it in one cycle;
// the head is read straight out of the storage registers.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic [CNT_W-1:0] count_nxt;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign do_pop = pop && head_valid;
    assign head   = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_nxt = count;
        case ({push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and the registered valid flag; flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-based issue to a synchronous
// ROM, and pairing of returned words with their PC into the output FIFO.
module fetch_unit #(
    parameter int          D_WIDTH    = riscv_pkg::D_WIDTH,
    parameter int          MEM_DEPTH  = riscv_pkg::MEM_DEPTH,
    parameter int          A_WIDTH    = $clog2(MEM_DEPTH),
    parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [D_WIDTH-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       out_if
);

    import riscv_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc;
    logic             req_q;
    logic [31:0]      req_pc_q;
    logic             issue;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W-1:0] count;
    logic             pop;
    fetch_entry_t     push_data;
    fetch_entry_t     head;
    logic             head_valid;
    logic             unused_redirect_lsbs;

    // Misaligned redirect bits are deliberately dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // The ROM only sees the word index, so addresses wrap modulo MEM_DEPTH.
    assign rom_addr = pc[A_WIDTH+1:2];

    // A fetch in flight already owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
    assign issue       = !redirect_valid && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    assign push_data.pc    = req_pc_q;
    assign push_data.instr = rom_data;
    assign pop             = head_valid && out_if.out_ready;

    // PC and in-flight request tracking; a redirect restarts from the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            req_q <= 1'b0;
        end else begin
            req_q <= issue;
            if (issue) begin
                pc       <= pc + 32'd4;
                req_pc_q <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (req_q),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign out_if.out_valid = head_valid;
    assign out_if.out_pc    = head.pc;
    assign out_if.out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus with a queue-based scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit_if #(.D_WIDTH(32)) bus ();

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_if         (bus)
    );

    // Synchronous instruction ROM, word i = A000_0000 + i
    logic [31:0] rom [1024];
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + 32'(i);
    end
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'hA000_0000 + {22'd0, pc[11:2]};
        return e;
    endfunction

    task automatic load_expected(input logic [31:0] start, input int n);
        expq.delete();
        for (int i = 0; i < n; i++) expq.push_back(model(start + 32'(4 * i)));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake is compared against the queue head
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: actual pc=%0h required=no entry", bus.out_pc);
            end else begin
                mon_e = expq.pop_front();
                check("stream_pc", 64'(bus.out_pc), 64'(mon_e.pc));
                check("stream_instr", 64'(bus.out_instr), 64'(mon_e.instr));
            end
        end
    end

    // Release reset with out_ready high and check the C0/C1/C2 latency
    task automatic release_reset();
        load_expected(32'h0, 200);
        cyc();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk); check("lat_c0_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_c1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_c2_valid", 64'(bus.out_valid), 64'd1);
    endtask

    // One-cycle redirect; checks the bubble and the issued addresses
    task automatic do_redirect(input logic [31:0] target);
        logic [31:0] t;
        logic [31:0] t4;
        t  = {target[31:2], 2'b00};
        t4 = t + 32'd4;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        load_expected(t, 200);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_r1_valid", 64'(bus.out_valid), 64'd0);
        check("redir_r1_addr", 64'(rom_addr), 64'(t[11:2]));
        @(negedge clk);
        check("redir_r2_valid", 64'(bus.out_valid), 64'd0);
        check("redir_r2_addr", 64'(rom_addr), 64'(t4[11:2]));
        @(negedge clk);
        check("redir_r3_valid", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_pc", 64'(bus.out_pc), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_count", 64'(dut.count), 64'd0);

        // Streaming from reset, one per cycle with no gaps
        release_reset();
        check("first_pc", 64'(bus.out_pc), 64'h0);
        check("first_instr", 64'(bus.out_instr), 64'hA000_0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stream_no_gap", 64'(bus.out_valid), 64'd1);
        end

        // Backpressure: FIFO fills, issue stops, stream resumes in order
        cyc();
        bus.out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("stall_count", 64'(dut.count), 64'd3);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_addr", 64'(rom_addr), 64'(expq[3].pc[11:2]));
        @(negedge clk);
        check("stall_addr_hold", 64'(rom_addr), 64'(expq[3].pc[11:2]));
        cyc();
        bus.out_ready = 1'b1;
        repeat (10) cyc();

        // Redirect mid-stream
        do_redirect(32'h0000_0100);
        check("redir100_pc", 64'(bus.out_pc), 64'h100);
        check("redir100_instr", 64'(bus.out_instr), 64'hA000_0040);
        @(negedge clk);
        check("redir104_pc", 64'(bus.out_pc), 64'h104);
        check("redir104_instr", 64'(bus.out_instr), 64'hA000_0041);
        repeat (4) cyc();

        // Redirect while full and stalled: all buffered entries discarded
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("full_count", 64'(dut.count), 64'd3);
        do_redirect(32'h0000_0200);
        check("full_redir_pc", 64'(bus.out_pc), 64'h200);
        check("full_redir_instr", 64'(bus.out_instr), 64'hA000_0080);
        cyc();
        bus.out_ready = 1'b1;
        repeat (8) cyc();

        // Misaligned target with ROM address wrap
        do_redirect(32'h0000_0FFE);
        check("wrap_pc", 64'(bus.out_pc), 64'hFFC);
        check("wrap_instr", 64'(bus.out_instr), 64'hA000_03FF);
        @(negedge clk);
        check("wrap_next_pc", 64'(bus.out_pc), 64'h1000);
        check("wrap_next_instr", 64'(bus.out_instr), 64'hA000_0000);
        repeat (4) cyc();

        // 32-bit PC wrap
        do_redirect(32'hFFFF_FFFC);
        check("pc32_pc", 64'(bus.out_pc), 64'hFFFF_FFFC);
        @(negedge clk);
        check("pc32_next_pc", 64'(bus.out_pc), 64'h0);
        repeat (4) cyc();

        // Reset with the FIFO partly full and a fetch in flight
        bus.out_ready = 1'b0;
        cyc();
        reset = 1'b1;
        @(posedge clk);
        expq.delete();
        @(negedge clk);
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_addr", 64'(rom_addr), 64'd0);
        check("midrst_count", 64'(dut.count), 64'd0);
        release_reset();
        check("midrst_first_pc", 64'(bus.out_pc), 64'h0);
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
